// File: rtl/period_to_freq_bcd.sv
// ============================================================================
// Module      : period_to_freq_bcd
// Description : Converts a period count into NUMERATOR/period, clamped to
//               0..9999, emitted as four BCD digits (restoring divide, then
//               double-dabble). Optional macro FREQ_ROUND_EN selects
//               round-to-nearest instead of truncation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_to_freq_bcd #(
    parameter int NUMERATOR = 10000000,
    parameter int NUM_W     = 24,
    parameter int PER_W     = 14
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [PER_W-1:0] iPeriod,
    input  logic             iPeriodValid,
    output logic             oBusy,
    output logic             oValid,
    output logic             oOverflow,
    output logic [3:0]       oThousands,
    output logic [3:0]       oHundreds,
    output logic [3:0]       oTens,
    output logic [3:0]       oUnits
);

    localparam int CNT_W = $clog2(NUM_W + 2);
    localparam int BIN_W = 14;
    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(NUM_W);
    localparam logic [CNT_W-1:0] c_BCD_LAST = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] c_MAX_OUT  = BIN_W'(9999);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIV  = 3'd1,
        S_SAT  = 3'd2,
        S_BCD  = 3'd3,
        S_DONE = 3'd4
    } t_state_e;

    t_state_e         r_state;
    t_state_e         w_stateNext;
    logic [PER_W-1:0] r_period;
    logic [NUM_W:0]   r_dividend;
    logic [PER_W:0]   r_rem;
    logic [NUM_W:0]   r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0] r_bin;
    logic [15:0]      r_bcd;
    logic             r_ovf;

    logic [NUM_W:0]   w_dividendInit;
    logic [PER_W:0]   w_remShift;
    logic [PER_W:0]   w_remNext;
    logic             w_ge;
    logic             w_clamp;
    logic [11:0]      w_bcdAdj;

`ifdef FREQ_ROUND_EN
    // The extra dividend bit absorbs the carry of the rounding term.
    assign w_dividendInit = (NUM_W+1)'(NUMERATOR) + (NUM_W+1)'(iPeriod >> 1);
`else
    assign w_dividendInit = (NUM_W+1)'(NUMERATOR);
`endif

    // A zero period never subtracts; its quotient is discarded in SAT anyway.
    assign w_remShift = {r_rem[PER_W-1:0], r_dividend[NUM_W]};
    assign w_ge       = (r_period != '0) &&
                        (r_rem[PER_W] || (w_remShift >= {1'b0, r_period}));
    assign w_remNext  = w_ge ? (w_remShift - {1'b0, r_period}) : w_remShift;
    assign w_clamp    = (r_period == '0) || (r_quot > (NUM_W+1)'(9999));

    // Thousands nibble is at most 4 before any shift, so it never needs adjusting.
    always_comb begin
        w_bcdAdj = r_bcd[11:0];
        for (int k = 0; k < 3; k++) begin
            if (r_bcd[k*4 +: 4] >= 4'd5) begin
                w_bcdAdj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (iPeriodValid) w_stateNext = S_DIV;
            S_DIV:   if (r_cnt == c_DIV_LAST) w_stateNext = S_SAT;
            S_SAT:   w_stateNext = S_BCD;
            S_BCD:   if (r_cnt == c_BCD_LAST) w_stateNext = S_DONE;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_period   <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            oBusy      <= 1'b0;
            oValid     <= 1'b0;
            oOverflow  <= 1'b0;
            oThousands <= '0;
            oHundreds  <= '0;
            oTens      <= '0;
            oUnits     <= '0;
        end else begin
            oValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iPeriodValid) begin
                        r_period   <= iPeriod;
                        r_dividend <= w_dividendInit;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_cnt      <= '0;
                        oBusy      <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem      <= w_remNext;
                    r_quot     <= {r_quot[NUM_W-1:0], w_ge};
                    r_dividend <= {r_dividend[NUM_W-1:0], 1'b0};
                    r_cnt      <= r_cnt + 1'b1;
                end
                S_SAT: begin
                    r_bin <= w_clamp ? c_MAX_OUT : r_quot[BIN_W-1:0];
                    r_ovf <= w_clamp;
                    r_bcd <= '0;
                    r_cnt <= '0;
                end
                S_BCD: begin
                    r_bcd <= {r_bcd[14:12], w_bcdAdj, r_bin[BIN_W-1]};
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    oThousands <= r_bcd[15:12];
                    oHundreds  <= r_bcd[11:8];
                    oTens      <= r_bcd[7:4];
                    oUnits     <= r_bcd[3:0];
                    oOverflow  <= r_ovf;
                    oValid     <= 1'b1;
                    oBusy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
